// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the 52-bit SEC-DED scrub controller.
//   scrub_state_e : background scrubber FSM states
//   CW            : codeword width (data + check bits)
//   CNT_WIDTH     : width of the saturating error counters
//   data_pos()    : Hamming position (1-based) of data bit idx; data bits
//                   fill the non-power-of-two positions in ascending order
package ecc_scrub_pkg;

    localparam int DATA_W    = 52;
    localparam int PAR_W     = 7;
    localparam int CW        = DATA_W + PAR_W;
    localparam int CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WB    = 3'd3,
        ADV   = 3'd4
    } scrub_state_e;

    function automatic int data_pos(int idx);
        int n;
        int p;
        n = 0;
        p = 0;
        for (int q = 1; q < 64; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == idx) p = q;
                n = n + 1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_52_top.sv
// SEC-DED encode/decode slice (extended Hamming).
//   parity[5:0] : Hamming checks over data positions
//   parity[6]   : overall parity of data and Hamming checks
// Ports:
//   bypass     in  : pass data/parity through, flags forced low
//   data_in    in  : data word (raw for decode, payload for encode)
//   parity_in  in  : stored check bits (ignored for pure encoding)
//   data_out   out : corrected data
//   parity_out out : freshly encoded check bits for data_in
//   sbit_err   out : single-bit error (data or check bit)
//   dbit_err   out : uncorrectable error
module ecc_52_top
    import ecc_scrub_pkg::*;
#(
    parameter int DATA_WIDTH   = 52,
    parameter int PARITY_WIDTH = 7
) (
    input  logic                    bypass,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    sbit_err,
    output logic                    dbit_err
);

    localparam int SW      = PARITY_WIDTH - 1;
    localparam int MAX_POS = data_pos(DATA_WIDTH - 1);

    logic [SW-1:0] pos [DATA_WIDTH];
    logic [SW-1:0] chk;
    logic [SW-1:0] syn;
    logic [DATA_WIDTH-1:0] corr;
    logic ovr_err, syn_zero, syn_pow2, syn_data;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pos
        localparam int P = data_pos(i);
        assign pos[i] = SW'(P);
    end

    always_comb begin
        chk = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            for (int b = 0; b < SW; b++)
                if (pos[i][b]) chk[b] = chk[b] ^ data_in[i];
    end

    assign syn      = chk ^ parity_in[SW-1:0];
    assign ovr_err  = ^{data_in, parity_in};
    assign syn_zero = (syn == '0);
    // Zero or a power of two: error sits in a check bit (or overall parity).
    assign syn_pow2 = ((syn & (syn - SW'(1))) == '0);
    // Syndromes above the last used data position cannot come from one flip.
    assign syn_data = ~syn_pow2 & (syn <= SW'(MAX_POS));

    always_comb begin
        corr = data_in;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (ovr_err && (syn == pos[i])) corr[i] = ~data_in[i];
    end

    assign data_out   = bypass ? data_in : corr;
    assign parity_out = bypass ? parity_in : {^{data_in, chk}, chk};
    assign sbit_err   = ~bypass & ovr_err & (syn_pow2 | syn_data);
    assign dbit_err   = ~bypass & ((~ovr_err & ~syn_zero) |
                                   (ovr_err & ~syn_pow2 & ~syn_data));

endmodule

// File: rtl/ecc_52_scrub_ctrl.sv
// RAM-side controller: arbitrates a single-port ECC RAM between a functional
// requester (priority) and a background scrubber that corrects single-bit
// errors by write-back and logs uncorrectable ones.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   scrub_en, interval    : scrub enable, idle cycles between scrub reads
//   cnt_clr               : sync clear of counters and dbit log
//   func_*                : functional request / grant / read response
//   mem_*                 : RAM strobe, write, address, {parity,data}, read data
//   scrub_addr, pass_done : scrub pointer, wrap pulse
//   sbit_cnt, dbit_cnt    : saturating scrub error counters
//   dbit_flag, dbit_addr  : sticky uncorrectable flag, last dbit address
module ecc_52_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int DATA_WIDTH     = 52,
    parameter int PARITY_WIDTH   = 7,
    parameter int ADDR_WIDTH     = 6,
    parameter int INTERVAL_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               scrub_en,
    input  logic [INTERVAL_WIDTH-1:0]          interval,
    input  logic                               cnt_clr,
    input  logic                               func_req,
    input  logic                               func_we,
    input  logic [ADDR_WIDTH-1:0]              func_addr,
    input  logic [DATA_WIDTH-1:0]              func_wdata,
    output logic                               func_gnt,
    output logic                               func_rvalid,
    output logic [DATA_WIDTH-1:0]              func_rdata,
    output logic                               func_sbit_err,
    output logic                               func_dbit_err,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0]              scrub_addr,
    output logic                               pass_done,
    output logic [CNT_WIDTH-1:0]               sbit_cnt,
    output logic [CNT_WIDTH-1:0]               dbit_cnt,
    output logic                               dbit_flag,
    output logic [ADDR_WIDTH-1:0]              dbit_addr
);

    scrub_state_e state, state_nxt;

    logic [INTERVAL_WIDTH-1:0] ivl_cnt;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      rd_pend;

    logic [DATA_WIDTH-1:0]     dec_data;
    logic [PARITY_WIDTH-1:0]   dec_par;
    logic                      dec_sbit, dec_dbit;

    logic [DATA_WIDTH-1:0]     enc_din, enc_dout;
    logic [PARITY_WIDTH-1:0]   enc_par;
    logic                      enc_sbit, enc_dbit;

    logic scrub_rd, scrub_wb, hazard, ivl_hit;
    logic inc_sbit, inc_dbit, adv, load_wb;
    logic unused_ecc;

    // Encoder: corrected scrub word during WB, functional write data otherwise.
    assign enc_din = (state == WB) ? wb_data : func_wdata;

    ecc_52_top #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc (
        .bypass     (1'b0),
        .data_in    (enc_din),
        .parity_in  ('0),
        .data_out   (enc_dout),
        .parity_out (enc_par),
        .sbit_err   (enc_sbit),
        .dbit_err   (enc_dbit)
    );

    ecc_52_top #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec (
        .bypass     (1'b0),
        .data_in    (mem_rdata[DATA_WIDTH-1:0]),
        .parity_in  (mem_rdata[DATA_WIDTH+PARITY_WIDTH-1:DATA_WIDTH]),
        .data_out   (dec_data),
        .parity_out (dec_par),
        .sbit_err   (dec_sbit),
        .dbit_err   (dec_dbit)
    );

    assign unused_ecc = ^{enc_dout, enc_sbit, enc_dbit, dec_par};

    assign func_gnt = func_req & (state != WB);
    // A functional write landing on the word being checked makes the
    // pending correction stale.
    assign hazard   = func_gnt & func_we & (func_addr == scrub_addr);
    assign ivl_hit  = (ivl_cnt >= interval);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scrub_rd  = 1'b0;
        scrub_wb  = 1'b0;
        inc_sbit  = 1'b0;
        inc_dbit  = 1'b0;
        adv       = 1'b0;
        load_wb   = 1'b0;
        case (state)
            IDLE:  if (scrub_en && ivl_hit) state_nxt = READ;
            READ: begin
                if (!scrub_en) state_nxt = IDLE;
                else if (!func_req) begin
                    scrub_rd  = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = ADV;
                if (dec_dbit) inc_dbit = 1'b1;
                else if (dec_sbit && !hazard) begin
                    load_wb   = 1'b1;
                    state_nxt = WB;
                end
            end
            WB: begin
                scrub_wb  = 1'b1;
                inc_sbit  = 1'b1;
                state_nxt = ADV;
            end
            ADV: begin
                adv       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scrub strobes only occur when func_gnt is low, so one strobe per cycle.
    assign mem_req   = func_gnt | scrub_rd | scrub_wb;
    assign mem_we    = scrub_wb | (func_gnt & func_we);
    assign mem_addr  = (scrub_rd | scrub_wb) ? scrub_addr :
                       (func_gnt ? func_addr : '0);
    assign mem_wdata = mem_we ? {enc_par, enc_din} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_cnt       <= '0;
            scrub_addr    <= '0;
            pass_done     <= 1'b0;
            wb_data       <= '0;
            sbit_cnt      <= '0;
            dbit_cnt      <= '0;
            dbit_flag     <= 1'b0;
            dbit_addr     <= '0;
            rd_pend       <= 1'b0;
            func_rvalid   <= 1'b0;
            func_rdata    <= '0;
            func_sbit_err <= 1'b0;
            func_dbit_err <= 1'b0;
        end else begin
            if (state == IDLE && scrub_en && !ivl_hit)
                ivl_cnt <= ivl_cnt + INTERVAL_WIDTH'(1);
            else
                ivl_cnt <= '0;

            if (adv) scrub_addr <= scrub_addr + ADDR_WIDTH'(1);
            pass_done <= adv && (scrub_addr == '1);

            if (load_wb) wb_data <= dec_data;

            if (cnt_clr) begin
                sbit_cnt  <= '0;
                dbit_cnt  <= '0;
                dbit_flag <= 1'b0;
                dbit_addr <= '0;
            end else begin
                if (inc_sbit && sbit_cnt != '1) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
                if (inc_dbit) begin
                    if (dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
                    dbit_flag <= 1'b1;
                    dbit_addr <= scrub_addr;
                end
            end

            // Functional read: strobe at N, RAM data at N+1, response at N+2.
            rd_pend       <= func_gnt & ~func_we;
            func_rvalid   <= rd_pend;
            func_rdata    <= rd_pend ? dec_data : '0;
            func_sbit_err <= rd_pend & dec_sbit;
            func_dbit_err <= rd_pend & dec_dbit;
        end
    end

endmodule
